// File: rtl/pc_pipe_gen.sv
// Fetch program counter with pipelined PC+INC copies, a pending-redirect buffer,
// vectored interrupt entry/return and a RUN/HALTED state machine.
module pc_pipe_gen #(
  parameter int unsigned        ADDR_W    = 16,
  parameter int unsigned        STAGES    = 3,
  parameter int unsigned        INC       = 1,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
  parameter logic [ADDR_W-1:0]  IRQ_VEC   = ADDR_W'(4)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_rdy,
  input  logic [STAGES-1:0]        stall,
  input  logic                     flow_change,
  input  logic [ADDR_W-1:0]        dst,
  input  logic                     irq_req,
  input  logic                     iret,
  input  logic                     halt,
  input  logic                     resume,
  output logic [ADDR_W-1:0]        pc,
  output logic [STAGES*ADDR_W-1:0] pc_stage,
  output logic [ADDR_W-1:0]        epc,
  output logic                     irq_ack,
  output logic                     in_isr,
  output logic                     halted
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   stg [STAGES];
  logic [ADDR_W-1:0]   pend_dst;
  logic                pend_valid;
  logic [ADDR_W-1:0]   pc_inc;
  logic                adv;
  logic                irq_ok;

  // A pending redirect must drain before an interrupt may be taken.
  always_comb begin
    pc_inc = pc + ADDR_W'(INC);
    adv    = i_rdy & ~stall[0] & (state == RUN);
    irq_ok = irq_req & ~in_isr & ~pend_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pc         <= RESET_VEC;
      epc        <= '0;
      irq_ack    <= 1'b0;
      in_isr     <= 1'b0;
      halted     <= 1'b0;
      pend_dst   <= '0;
      pend_valid <= 1'b0;
      for (int k = 0; k < int'(STAGES); k++) stg[k] <= '0;
    end else begin
      irq_ack <= 1'b0;
      if (iret) in_isr <= 1'b0;

      if (state == RUN) begin
        if (adv) begin
          if (flow_change || pend_valid) begin
            pc         <= flow_change ? dst : pend_dst;
            pend_valid <= 1'b0;
          end else if (irq_ok) begin
            epc     <= pc_inc;
            pc      <= IRQ_VEC;
            irq_ack <= 1'b1;
            in_isr  <= 1'b1;
          end else if (halt) begin
            pc     <= pc_inc;
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            pc <= pc_inc;
          end
        end else if (flow_change) begin
          pend_dst   <= dst;
          pend_valid <= 1'b1;
        end
      end else begin
        // Interrupt wake-up enters the handler regardless of stall/i_rdy.
        if (flow_change) begin
          pend_dst   <= dst;
          pend_valid <= 1'b1;
        end
        if (irq_ok) begin
          epc     <= pc_inc;
          pc      <= IRQ_VEC;
          irq_ack <= 1'b1;
          in_isr  <= 1'b1;
          state   <= RUN;
          halted  <= 1'b0;
        end else if (resume) begin
          state  <= RUN;
          halted <= 1'b0;
        end
      end

      if (adv) stg[0] <= pc_inc;
      for (int k = 1; k < int'(STAGES); k++) begin
        if (!stall[k]) stg[k] <= stg[k-1];
      end
    end
  end

  for (genvar g = 0; g < int'(STAGES); g++) begin : g_pack
    assign pc_stage[g*ADDR_W +: ADDR_W] = stg[g];
  end

endmodule
